booth_mul_seq: RTL and testbench

Sequential signed 8×8 → 16-bit multiplier controller. It uses radix-2 Booth recoding and time-shares a single instance of the team's 8-bit AdderSubtractor, issuing one add, subtract or no-op per cycle. Operands enter and the product leaves through valid/ready handshakes. The block sits between the operand-entry front end and the result display/accumulator logic.

---
 rtl/booth_mul_pkg.sv | 28 ++
 rtl/booth_mul_seq_adder_subtractor.sv | 24 ++
 rtl/booth_mul_seq.sv | 129 ++++++++++++
 tb/tb_booth_mul_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/booth_mul_pkg.sv
// rtl/booth_mul_pkg.sv - shared types and constants for the sequential Booth multiplier
package booth_mul_pkg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } booth_op_t;

    // Radix-2 Booth recoding of the current multiplier bit pair {Q[0], q_m1}.
    function automatic booth_op_t booth_op(input logic q0, input logic qm1);
        case ({q0, qm1})
            2'b01:   return OP_ADD;
            2'b10:   return OP_SUB;
            default: return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_mul_seq_adder_subtractor.sv
// rtl/booth_mul_seq_adder_subtractor.sv - 8-bit adder/subtractor, c0 selects subtract
module booth_mul_seq_adder_subtractor (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       c0,
    output logic [7:0] s,
    output logic       c7,
    output logic       c8,
    output logic       e
);

    logic [7:0] y_eff;
    logic [7:0] low;

    assign y_eff = y ^ {8{c0}};
    // Low seven bits summed separately so the carry into the MSB is visible.
    assign low   = {1'b0, x[6:0]} + {1'b0, y_eff[6:0]} + {7'd0, c0};

    assign c7    = low[7];
    assign s     = {x[7] ^ y_eff[7] ^ c7, low[6:0]};
    assign c8    = (x[7] & y_eff[7]) | (x[7] & c7) | (y_eff[7] & c7);
    assign e     = c7 ^ c8;

endmodule

// File: rtl/booth_mul_seq.sv
// rtl/booth_mul_seq.sv - signed 8x8 radix-2 Booth multiplier, one iteration per cycle
module booth_mul_seq #(
    parameter int WIDTH = booth_mul_pkg::WIDTH,
    parameter int CNT_W = booth_mul_pkg::CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    import booth_mul_pkg::*;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   q;
    logic               q_m1;
    logic [WIDTH-1:0]   m;
    logic [CNT_W-1:0]   cnt;

    booth_op_t          op;
    logic [WIDTH-1:0]   add_x;
    logic [WIDTH-1:0]   add_y;
    logic               add_c0;
    logic [WIDTH-1:0]   add_s;
    logic               add_c7;
    logic               add_c8;
    logic               add_e;
    logic [WIDTH-1:0]   sel;
    logic               sgn;
    logic               unused_carries;

    assign op             = booth_op(q[0], q_m1);
    assign unused_carries = add_c7 ^ add_c8;

    // Adder inputs stay at zero outside RUN and on no-op cycles to avoid toggling.
    always_comb begin
        add_x  = '0;
        add_y  = '0;
        add_c0 = 1'b0;
        if (state == RUN && op != OP_NOP) begin
            add_x  = acc;
            add_y  = m;
            add_c0 = (op == OP_SUB);
        end
    end

    booth_mul_seq_adder_subtractor u_addsub (
        .x  (add_x),
        .y  (add_y),
        .c0 (add_c0),
        .s  (add_s),
        .c7 (add_c7),
        .c8 (add_c8),
        .e  (add_e)
    );

    // Overflow flag restores the true 9-bit sign, e.g. 0 - (-128).
    always_comb begin
        sel = acc;
        sgn = acc[WIDTH-1];
        if (op != OP_NOP) begin
            sel = add_s;
            sgn = add_s[WIDTH-1] ^ add_e;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            acc          <= '0;
            q            <= '0;
            q_m1         <= 1'b0;
            m            <= '0;
            cnt          <= '0;
            start_ready  <= 1'b1;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        m           <= a;
                        q           <= b;
                        acc         <= '0;
                        q_m1        <= 1'b0;
                        cnt         <= '0;
                        state       <= RUN;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                RUN: begin
                    {acc, q, q_m1} <= {sgn, sel, q};
                    cnt            <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        state        <= DONE;
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        state        <= IDLE;
                        result_valid <= 1'b0;
                        start_ready  <= 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    start_ready  <= 1'b1;
                    result_valid <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

    assign product = {acc, q};

endmodule

// File: tb/tb_booth_mul_seq.sv
// tb/tb_booth_mul_seq.sv - scoreboard bench for booth_mul_seq
module tb_booth_mul_seq;

    logic        clk;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        result_valid;
    logic        result_ready;
    logic [15:0] product;
    logic        busy;

    int          n_checks;
    int          n_fail;
    int          cyc;
    logic [15:0] sb[$];

    booth_mul_seq #(.WIDTH(8), .CNT_W(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .a            (a),
        .b            (b),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .product      (product),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
        logic signed [15:0] p;
        p = $signed(x) * $signed(y);
        return p;
    endfunction

    // Product is compared the cycle before the transfer edge.
    always @(negedge clk) begin
        if (!rst && result_valid && result_ready) begin
            if (sb.size() == 0) check("sb_underflow", 16'd1, 16'd0);
            else check("product", product, sb.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        tick();
        check(tag, 16'(sb.size()), 16'd0);
    endtask

    task automatic run_simple(input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp);
        tick();
        a = x;
        b = y;
        start_valid = 1'b1;
        sb.push_back(exp);
        check("model", ref_mul(x, y), exp);
        tick();
        start_valid = 1'b0;
        drain("drain");
    endtask

    initial begin
        int busy_cnt;
        int first_valid;
        logic sr_at10;
        int guard;
        int n_acc;
        int acc_cyc[3];
        logic [7:0] pa[3];
        logic [7:0] pb[3];

        n_checks = 0;
        n_fail = 0;
        cyc = 0;
        rst = 1'b1;
        start_valid = 1'b0;
        a = '0;
        b = '0;
        result_ready = 1'b1;
        #1;
        check("rst_start_ready", 16'(start_ready), 16'd1);
        check("rst_result_valid", 16'(result_valid), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_product", product, 16'd0);
        tick();
        tick();
        rst = 1'b0;

        // 7 x 3 with latency and busy-width checks
        tick();
        a = 8'd7;
        b = 8'd3;
        start_valid = 1'b1;
        sb.push_back(16'h0015);
        tick();
        start_valid = 1'b0;
        busy_cnt = 0;
        first_valid = 0;
        sr_at10 = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (result_valid && first_valid == 0) first_valid = k;
            if (k == 10) sr_at10 = start_ready;
        end
        check("busy_cycles", 16'(busy_cnt), 16'd8);
        check("latency", 16'(first_valid), 16'd9);
        check("start_ready_after_t9", 16'(sr_at10), 16'd1);
        check("sb_7x3", 16'(sb.size()), 16'd0);

        run_simple(8'h80, 8'h80, 16'h4000);
        run_simple(8'h80, 8'h7F, 16'hC080);
        run_simple(8'hFF, 8'hFF, 16'h0001);
        run_simple(8'h00, 8'h5A, 16'h0000);

        // back-pressure
        result_ready = 1'b0;
        tick();
        a = 8'h80;
        b = 8'h7F;
        start_valid = 1'b1;
        sb.push_back(16'hC080);
        tick();
        start_valid = 1'b0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!result_valid && guard < 20);
        check("bp_reach_done", 16'(result_valid), 16'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            start_valid = (i == 1);
            a = 8'd1;
            b = 8'd1;
            @(negedge clk);
            check("bp_product", product, 16'hC080);
            check("bp_start_ready", 16'(start_ready), 16'd0);
            check("bp_valid", 16'(result_valid), 16'd1);
        end
        tick();
        start_valid = 1'b0;
        result_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_start_ready_rise", 16'(start_ready), 16'd1);
        check("bp_valid_drop", 16'(result_valid), 16'd0);
        check("bp_pulse_ignored", 16'(busy), 16'd0);
        check("bp_sb", 16'(sb.size()), 16'd0);

        // reset at T4 of a run
        tick();
        a = 8'd3;
        b = 8'd3;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_start_ready", 16'(start_ready), 16'd1);
        check("mid_rst_valid", 16'(result_valid), 16'd0);
        check("mid_rst_busy", 16'(busy), 16'd0);
        check("mid_rst_product", product, 16'd0);
        tick();
        rst = 1'b0;
        run_simple(8'd5, 8'hFA, 16'hFFE2);

        // back-to-back with inputs tied high
        pa[0] = 8'h13; pb[0] = 8'hE7;
        pa[1] = 8'h80; pb[1] = 8'h01;
        pa[2] = 8'h7F; pb[2] = 8'h7F;
        n_acc = 0;
        tick();
        a = pa[0];
        b = pb[0];
        start_valid = 1'b1;
        result_ready = 1'b1;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (start_ready && start_valid && n_acc < 3) begin
                acc_cyc[n_acc] = cyc;
                sb.push_back(ref_mul(pa[n_acc], pb[n_acc]));
                n_acc++;
                tick();
                if (n_acc < 3) begin
                    a = pa[n_acc];
                    b = pb[n_acc];
                end else begin
                    start_valid = 1'b0;
                end
            end
        end
        check("b2b_accepts", 16'(n_acc), 16'd3);
        if (n_acc == 3) begin
            check("b2b_interval_1", 16'(acc_cyc[1] - acc_cyc[0]), 16'd10);
            check("b2b_interval_2", 16'(acc_cyc[2] - acc_cyc[1]), 16'd10);
        end
        check("b2b_exp_known", ref_mul(8'h7F, 8'h7F), 16'h3F01);
        drain("b2b_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
